// File: rtl/ecall_print_uart.sv
// ecall_print_uart: takes the characters the core prints through ecall, buffers
// them in a FIFO and sends them out on a UART TX line framed as 8N1.
// Once halt has been seen and all buffered output has been sent, drained goes high.
// Optional feature: define UART_PARITY_EN to add an even-parity bit after the data bits.
module ecall_print_uart #(
  parameter int unsigned FIFO_DEPTH   = 16,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               print_flag,
  input  logic [7:0]                         print_char,
  input  logic                               halt,
  output logic                               tx,
  output logic                               busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
  output logic                               overflow,
  output logic                               drained
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] Depth   = CW'(FIFO_DEPTH);
  localparam logic [BW-1:0] BaudMax = BW'(CLKS_PER_BIT - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
`ifdef UART_PARITY_EN
  logic            par_q, par_d;
`endif
  logic            tx_d, busy_d, drained_d;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic            flag_q, halt_q, ovf_q;
  logic            push_req, push, pop, full;

  // Rising-edge detect on print_flag and push/pop arbitration.
  always_comb begin
    push_req = print_flag & ~flag_q;
    full     = (count_q == Depth);
    pop      = (state_q == StIdle) && (count_q != '0);
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    push     = push_req & (~full | pop);
  end

  // Character storage; no reset needed, entries are only read after a write.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= print_char;
  end

  // FIFO pointers, count, sticky flags and input history.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      flag_q   <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      flag_q <= print_flag;
      if (halt) halt_q <= 1'b1;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      if (push_req && full && !pop) ovf_q <= 1'b1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Transmit FSM next state; outputs derive from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
`ifdef UART_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (pop) begin
          shift_d = mem[rd_ptr_q];
`ifdef UART_PARITY_EN
          par_d   = ^mem[rd_ptr_q];
`endif
          baud_d  = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_q == BaudMax) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          state_d = StData;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      StData: begin
        if (baud_q == BaudMax) begin
          baud_d  = '0;
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (baud_q == BaudMax) begin
          baud_d  = '0;
          state_d = StStop;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      StStop: begin
        if (baud_q == BaudMax) begin
          baud_d  = '0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    tx_d = 1'b1;
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[0];
`ifdef UART_PARITY_EN
      StParity: tx_d = par_d;
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d    = (state_d != StIdle);
    drained_d = halt_q && (count_q == '0) && (state_q == StIdle);
  end

  // FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= 3'd0;
      shift_q   <= 8'h00;
`ifdef UART_PARITY_EN
      par_q     <= 1'b0;
`endif
      tx        <= 1'b1;
      busy      <= 1'b0;
      drained   <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef UART_PARITY_EN
      par_q     <= par_d;
`endif
      tx        <= tx_d;
      busy      <= busy_d;
      drained   <= drained_d;
    end
  end

  assign fifo_count = count_q;
  assign overflow   = ovf_q;

endmodule

// File: doc/ecall_print_uart.md
Name: ecall_print_uart

Overview:
- Downstream consumer of the CPU top's ecall print path.
- Captures each character the core prints (print_flag event, character from register a1) into a FIFO.
- Serializes the characters onto a standard 8N1 UART TX line.
- Reports when the program has halted and all output has drained, so benches wait on drained rather than halt.

Parameters:
- FIFO_DEPTH, 16, character buffer entries; power of two, >= 2.
- CLKS_PER_BIT, 4, clk cycles per UART bit; >= 2.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- print_flag  input  1  ecall print indication from the core; a rising edge marks one character.
- print_char  input  8  character to print (low byte of a1); sampled in the cycle print_flag rises.
- halt  input  1  ecall halt from the core.
- tx  output  1  UART serial output; idles high.
- busy  output  1  high while a frame is on tx (FSM not IDLE).
- fifo_count  output  $clog2(FIFO_DEPTH+1)  characters buffered, not yet started.
- overflow  output  1  sticky; set when a character is dropped because the FIFO is full.
- drained  output  1  halt has been seen, FIFO is empty and the FSM is IDLE.

Behaviour:
- Reset (rst high at a clk edge):
  - Outputs: tx=1, busy=0, fifo_count=0, overflow=0, drained=0.
  - Internal state: FSM=IDLE, halt latch=0, print_flag history=0.
  - Reset mid-frame abandons the frame; tx is high from the reset edge onward.
- Capture:
  - Register print_flag.
  - Push print_char when print_flag=1 and the registered value=0. A level held high yields exactly one push.
- FIFO:
  - Circular buffer with wrap-around read/write pointers.
  - Push when full: the character is dropped, overflow=1 until rst, count unchanged.
  - Push and pop in the same cycle: both succeed, count unchanged. This holds even when the FIFO is full.
  - Push into an empty FIFO: the entry is visible next cycle.
- FSM states: IDLE, START, DATA, STOP. A baud counter runs 0..CLKS_PER_BIT-1; a bit index runs 0..7.
  - IDLE: tx=1. If fifo_count>0, pop the head into the shift register and go to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0], LSB first, each bit held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - IDLE always lasts at least one cycle, so back-to-back frames have a 1-cycle idle gap. Frame period is 10*CLKS_PER_BIT+1 cycles.
- Latency:
  - Character captured at edge E0; the FSM pops at E1; tx=0 from E1.
  - The first start bit begins one cycle after capture.
- Halt:
  - halt=1 at any edge sets a sticky latch, cleared only by rst.
  - Captures remain enabled after halt. An ecall print in the same cycle as halt is still emitted.
  - drained = halt latch & (fifo_count==0) & IDLE, registered. It rises one cycle after the last stop bit ends.
  - If halt arrives with an empty FIFO and IDLE, drained=1 one cycle after the halt edge.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for CLKS_PER_BIT cycles.
  - Frame period becomes 11*CLKS_PER_BIT+1.
- Undefined: 8N1 framing exactly as above, and no PARITY state exists in the RTL.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=16):
1. Single character:
   - Stimulus: pulse print_flag 1 cycle with print_char=8'h41 ('A').
   - Response: tx=0 for cycles 1-4 after capture, then data bits 1,0,0,0,0,0,1,0 (4 cycles each), stop=1 for 4 cycles. busy=1 for exactly 40 cycles.
2. Held flag:
   - Stimulus: hold print_flag high 10 cycles with print_char=8'h42.
   - Response: exactly one push (fifo_count peaks at 1); a single 'B' frame.
3. Overflow:
   - Stimulus: push 18 characters 2 cycles apart while the first frame is in flight.
   - Response: fifo_count saturates at 16 and overflow=1. The first 17 characters are transmitted in order; the 18th is lost.
4. Halt drain:
   - Stimulus: push "Hi" (8'h48, 8'h69), assert halt the next cycle.
   - Response: drained stays 0 through both frames (81 cycles). drained=1 one cycle after the second stop bit ends.
5. Reset mid-frame:
   - Stimulus: rst during DATA bit 3 with 3 characters queued.
   - Response: the next cycle shows tx=1, busy=0, fifo_count=0, overflow=0; no further frames.
6. UART_PARITY_EN:
   - Stimulus: send 8'h07.
   - Response: parity bit=1 after bit 7, then stop; frame period 45 cycles.
